i2s_sample_sched: RTL and testbench



---
 rtl/i2s_sched_pkg.sv | 28 ++
 rtl/i2s_sched_fallback_timer.sv | 39 +++
 rtl/i2s_sample_sched.sv | 187 ++++++++++++++++++
 tb/tb_i2s_sample_sched.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_sched_pkg.sv
// i2s_sched_pkg: shared definitions for the I2S sample scheduler.
//   - mode codes driven on the scheduler's 'mode' input
//   - scheduler state encoding
//   - default sample width / stream timeout
//   - cnt_width(): width of a counter that must hold 0..t (at least 1 bit)
package i2s_sched_pkg;

  localparam int DEF_W       = 16;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    MODE_TONE   = 2'd0,
    MODE_STREAM = 2'd1,
    MODE_PREF   = 2'd2,
    MODE_MUTE   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STAGED = 2'd2
  } state_e;

  function automatic int cnt_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/i2s_sched_fallback_timer.sv
// i2s_sched_fallback_timer: saturating wait counter used while fetching in
// stream-preferred mode. Counts FETCH cycles; 'expired' is high once the
// count has reached TIMEOUT (immediately when TIMEOUT = 0). Never wraps.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clr        force count to 0 on the next cycle (wins over en)
//   en         count this cycle
//   expired    count == TIMEOUT
module i2s_sched_fallback_timer
  import i2s_sched_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            CW    = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                       cnt_d = '0;
    else if (en && cnt_q != LIMIT) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/i2s_sample_sched.sv
// i2s_sample_sched: arbitrates the I2S slave shifter between the tone
// generator (s0) and the USB stream (s1). After each lrclk edge it fetches
// one sample for the following slot, stages it, and hands it to the shifter
// one cycle after the next edge. A slot that ends without a usable sample
// gets the channel's last sample (0 when muted) and an underrun pulse.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   lr_edge, lr_ws       synchronised lrclk change pulse and new word select
//   mode                 0 tone, 1 stream, 2 stream w/ tone fallback, 3 mute
//   s0_*, s1_*           valid/ready sample sources (ready gated by ~rst)
//   out_data/ch/load     sample, channel and reload pulse for the shifter
//   underrun             pulse with out_load when a fallback was presented
//   busy                 high while fetching
// Optional (macro I2S_SCHED_STATS_EN): stat_clr input and saturating 16-bit
// underrun_cnt output.
module i2s_sample_sched
  import i2s_sched_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         lr_edge,
  input  logic         lr_ws,
  input  logic [1:0]   mode,
  input  logic [W-1:0] s0_data,
  input  logic         s0_valid,
  output logic         s0_ready,
  input  logic [W-1:0] s1_data,
  input  logic         s1_valid,
  output logic         s1_ready,
  output logic [W-1:0] out_data,
  output logic         out_load,
  output logic         out_ch,
  output logic         underrun,
  output logic         busy
`ifdef I2S_SCHED_STATS_EN
  ,
  input  logic         stat_clr,
  output logic [15:0]  underrun_cnt
`endif
);

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic                tc_q, tc_d;          // channel being fetched for
  logic [W-1:0]        stg_data_q, stg_data_d;
  logic                stg_tag_q, stg_tag_d;
  logic [1:0][W-1:0]   last_q, last_d;      // hold-last per channel
  logic [W-1:0]        out_data_q, out_data_d;
  logic                out_load_q, out_load_d;
  logic                out_ch_q, out_ch_d;
  logic                underrun_q, underrun_d;

  logic         in_fetch, hs0, hs1, mute_take, take;
  logic [W-1:0] take_data;
  logic         timer_clr, expired;
  logic         avail, avail_tag;
  logic [W-1:0] avail_data;

  i2s_sched_fallback_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (in_fetch),
    .expired (expired)
  );

  assign in_fetch = (state_q == FETCH);

  // s1 wins a same-cycle collision in PREF: s0_ready drops whenever s1 fires.
  assign s1_ready = ~rst & in_fetch & (mode_q == MODE_STREAM || mode_q == MODE_PREF);
  assign hs1      = s1_valid & s1_ready;
  assign s0_ready = ~rst & in_fetch &
                    ((mode_q == MODE_TONE) || (mode_q == MODE_PREF && expired && !hs1));
  assign hs0      = s0_valid & s0_ready;

  // Mute "transfers" a zero on the first FETCH cycle without touching last[].
  assign mute_take = ~rst & in_fetch & (mode_q == MODE_MUTE);
  assign take      = hs0 | hs1 | mute_take;
  assign take_data = hs1 ? s1_data : (hs0 ? s0_data : '0);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    tc_d       = tc_q;
    stg_data_d = stg_data_q;
    stg_tag_d  = stg_tag_q;
    last_d     = last_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    out_load_d = 1'b0;
    underrun_d = 1'b0;
    timer_clr  = !in_fetch;
    avail      = 1'b0;
    avail_data = stg_data_q;
    avail_tag  = stg_tag_q;

    case (state_q)
      IDLE: ;
      FETCH: begin
        if (take) begin
          stg_data_d = take_data;
          stg_tag_d  = tc_q;
          if (hs0 || hs1) last_d[tc_q] = take_data;
          state_d    = STAGED;
          // a transfer landing on the edge cycle still counts for this slot
          avail      = 1'b1;
          avail_data = take_data;
          avail_tag  = tc_q;
        end
      end
      STAGED:  avail = 1'b1;
      default: state_d = IDLE;
    endcase

    if (lr_edge) begin
      out_load_d = 1'b1;
      out_ch_d   = lr_ws;
      tc_d       = ~lr_ws;
      mode_d     = mode_e'(mode);
      state_d    = FETCH;
      timer_clr  = 1'b1;
      if (state_q == IDLE) begin
        out_data_d = '0;
      end else if (avail && avail_tag == lr_ws) begin
        out_data_d = avail_data;
      end else begin
        // starved slot, or staged sample tagged for the other channel
        out_data_d = (mode_q == MODE_MUTE) ? '0 : last_q[lr_ws];
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= MODE_TONE;
      tc_q       <= 1'b0;
      stg_data_q <= '0;
      stg_tag_q  <= 1'b0;
      last_q     <= '0;
      out_data_q <= '0;
      out_load_q <= 1'b0;
      out_ch_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      tc_q       <= tc_d;
      stg_data_q <= stg_data_d;
      stg_tag_q  <= stg_tag_d;
      last_q     <= last_d;
      out_data_q <= out_data_d;
      out_load_q <= out_load_d;
      out_ch_q   <= out_ch_d;
      underrun_q <= underrun_d;
    end
  end

  assign out_data = out_data_q;
  assign out_load = out_load_q;
  assign out_ch   = out_ch_q;
  assign underrun = underrun_q;
  assign busy     = in_fetch;

`ifdef I2S_SCHED_STATS_EN
  logic [15:0] underrun_cnt_q, underrun_cnt_d;

  // counts the visible underrun pulse; clear has priority
  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    if (stat_clr)                                    underrun_cnt_d = '0;
    else if (underrun_q && underrun_cnt_q != 16'hFFFF) underrun_cnt_d = underrun_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) underrun_cnt_q <= '0;
    else     underrun_cnt_q <= underrun_cnt_d;
  end

  assign underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_sample_sched.sv
module tb_i2s_sample_sched;
  localparam int W  = 16;
  localparam int TO = 8;

  logic         clk = 1'b0, rst = 1'b1, lr_edge = 1'b0, lr_ws = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [W-1:0] s0_data = '0, s1_data = '0;
  logic         s0_valid = 1'b0, s1_valid = 1'b0;
  logic         s0_ready, s1_ready, out_load, out_ch, underrun, busy;
  logic [W-1:0] out_data;
`ifdef I2S_SCHED_STATS_EN
  logic         stat_clr = 1'b0;
  logic [15:0]  underrun_cnt;
`endif

  int tests = 0, fails = 0;

  i2s_sample_sched #(.W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .lr_edge(lr_edge), .lr_ws(lr_ws), .mode(mode),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
    .out_data(out_data), .out_load(out_load), .out_ch(out_ch),
    .underrun(underrun), .busy(busy)
`ifdef I2S_SCHED_STATS_EN
    , .stat_clr(stat_clr), .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // inputs change 2 time units after the active edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // ---------------- slot-level reference model ----------------
  // Tracks, per slot: whether a sample has been obtained, the sample and
  // which channel it was fetched for, FETCH cycles waited, hold-last values.
  bit          m_started, m_have, m_htag, m_tgt;
  logic [15:0] m_hdata;
  int          m_waited;
  logic [1:0]  m_mode;
  logic [15:0] m_last [2];
  logic [15:0] e_data;
  bit          e_load, e_ch, e_ur;
  int          e_cnt;
  bit          fetching, r0, r1, take;
  logic [15:0] tdata;

  initial begin
    m_started = 0; m_have = 0; m_htag = 0; m_tgt = 0; m_hdata = 0;
    m_waited = 0; m_mode = 0; m_last[0] = 0; m_last[1] = 0;
    e_data = 0; e_load = 0; e_ch = 0; e_ur = 0; e_cnt = 0;
  end

  always @(negedge clk) begin
    chk("out_load", out_load, e_load);
    chk("out_data", out_data, e_data);
    chk("out_ch", out_ch, e_ch);
    chk("underrun", underrun, e_ur);
`ifdef I2S_SCHED_STATS_EN
    chk("underrun_cnt", underrun_cnt, e_cnt);
`endif
    fetching = m_started && !m_have;
    r1 = !rst && fetching && (m_mode == 2'd1 || m_mode == 2'd2);
    r0 = !rst && fetching &&
         (m_mode == 2'd0 || (m_mode == 2'd2 && m_waited >= TO && !s1_valid));
    chk("busy", busy, fetching);
    chk("s0_ready", s0_ready, r0);
    chk("s1_ready", s1_ready, r1);

    if (rst) begin
      m_started = 0; m_have = 0; m_waited = 0; m_mode = 0;
      m_last[0] = 0; m_last[1] = 0;
      e_data = 0; e_load = 0; e_ch = 0; e_ur = 0; e_cnt = 0;
    end else begin
`ifdef I2S_SCHED_STATS_EN
      if (stat_clr) e_cnt = 0;
      else if (e_ur && e_cnt < 65535) e_cnt++;
`endif
      e_load = 0; e_ur = 0;
      take  = (r0 && s0_valid) || (r1 && s1_valid) || (fetching && m_mode == 2'd3);
      tdata = (r1 && s1_valid) ? s1_data : ((r0 && s0_valid) ? s0_data : 16'h0);
      if (take) begin
        m_have = 1; m_hdata = tdata; m_htag = m_tgt;
        if (m_mode != 2'd3) m_last[m_tgt] = tdata;
      end else if (fetching && m_waited < TO) begin
        m_waited++;
      end
      if (lr_edge) begin
        e_load = 1; e_ch = lr_ws;
        if (!m_started)                   e_data = 0;
        else if (m_have && m_htag == lr_ws) e_data = m_hdata;
        else begin
          e_data = (m_mode == 2'd3) ? 16'h0 : m_last[lr_ws];
          e_ur = 1;
        end
        m_started = 1; m_have = 0; m_waited = 0; m_tgt = !lr_ws; m_mode = mode;
      end
    end
  end

  // ---------------- directed sequences ----------------
  typedef struct {
    logic        ws;      // edge word select
    logic [15:0] exp_d;   // expected presented sample
    logic        exp_ur;  // expected underrun
    logic [1:0]  n_mode;  // inputs for the fetch that follows
    logic        n_s0v;
    logic [15:0] n_s0d;
    logic        n_s1v;
    logic [15:0] n_s1d;
    int          gap;     // cycles until the next edge
  } slot_t;

  slot_t tbl [9];

  task automatic edge_present(input logic ws, input logic [15:0] exp_d,
                              input logic exp_ur, input string tag);
    lr_edge = 1'b1; lr_ws = ws;
    cyc();
    lr_edge = 1'b0;
    chk({tag, " load"}, out_load, 1'b1);
    chk({tag, " data"}, out_data, exp_d);
    chk({tag, " ur"},   underrun, exp_ur);
    chk({tag, " ch"},   out_ch,   ws);
  endtask

  initial begin
    tbl[0] = '{1'b0, 16'h0000, 1'b0, 2'd0, 1'b1, 16'h1111, 1'b0, 16'h0000, 62};
    tbl[1] = '{1'b1, 16'h1111, 1'b0, 2'd0, 1'b1, 16'h2222, 1'b0, 16'h0000, 62};
    tbl[2] = '{1'b0, 16'h2222, 1'b0, 2'd2, 1'b1, 16'hAAAA, 1'b0, 16'h0000, 20};
    tbl[3] = '{1'b1, 16'hAAAA, 1'b0, 2'd1, 1'b0, 16'h0000, 1'b1, 16'h3C3C, 20};
    tbl[4] = '{1'b0, 16'h3C3C, 1'b0, 2'd1, 1'b0, 16'h0000, 1'b1, 16'h7F00, 20};
    tbl[5] = '{1'b1, 16'h7F00, 1'b0, 2'd1, 1'b0, 16'h0000, 1'b0, 16'h0000, 20};
    tbl[6] = '{1'b0, 16'h3C3C, 1'b1, 2'd1, 1'b0, 16'h0000, 1'b0, 16'h0000, 20};
    tbl[7] = '{1'b1, 16'h7F00, 1'b1, 2'd3, 1'b0, 16'h0000, 1'b0, 16'h0000, 20};
    tbl[8] = '{1'b0, 16'h0000, 1'b0, 2'd2, 1'b0, 16'h0000, 1'b0, 16'h0000, 0};

    rst = 1'b1;
    repeat (3) cyc();
    chk("reset out_load", out_load, 1'b0);
    chk("reset out_data", out_data, 16'h0);
    chk("reset busy", busy, 1'b0);
    chk("reset s0_ready", s0_ready, 1'b0);
    rst = 1'b0;
    repeat (2) cyc();

    for (int i = 0; i < 9; i++) begin
      mode     = tbl[i].n_mode;
      s0_valid = tbl[i].n_s0v; s0_data = tbl[i].n_s0d;
      s1_valid = tbl[i].n_s1v; s1_data = tbl[i].n_s1d;
      edge_present(tbl[i].ws, tbl[i].exp_d, tbl[i].exp_ur, $sformatf("slot%0d", i));
      repeat (tbl[i].gap) cyc();
    end

`ifdef I2S_SCHED_STATS_EN
    chk("stats two underruns", underrun_cnt, 16'd2);
    stat_clr = 1'b1; cyc(); stat_clr = 1'b0;
    chk("stats cleared", underrun_cnt, 16'd0);
`endif

    // s0 and s1 valid together after the timeout: only s1 transfers
    repeat (10) cyc();
    chk("t3 s0_ready after timeout", s0_ready, 1'b1);
    s0_valid = 1'b1; s0_data = 16'h1234; s1_valid = 1'b1; s1_data = 16'h5555;
    #1;
    chk("t3 s0_ready forced low", s0_ready, 1'b0);
    chk("t3 s1_ready", s1_ready, 1'b1);
    cyc();
    s0_valid = 1'b0; s1_valid = 1'b0;
    #1;
    chk("t3 staged not busy", busy, 1'b0);
    mode = 2'd1;
    edge_present(1'b1, 16'h5555, 1'b0, "t3");

    // edge coincides with a stream handshake
    repeat (5) cyc();
    s1_valid = 1'b1; s1_data = 16'h0042;
    edge_present(1'b0, 16'h0042, 1'b0, "t5");
    s1_valid = 1'b0;

    // reset mid-FETCH with s1 offering data
    cyc();
    rst = 1'b1; s1_valid = 1'b1; s1_data = 16'hBEEF;
    #1;
    chk("t6 ready gated by rst", s1_ready, 1'b0);
    cyc();
    rst = 1'b0;
    #1;
    chk("t6 s1_ready after rst", s1_ready, 1'b0);
    chk("t6 idle after rst", busy, 1'b0);
    chk("t6 out_data after rst", out_data, 16'h0);
    s1_valid = 1'b0; mode = 2'd0;
    cyc();
    edge_present(1'b0, 16'h0000, 1'b0, "t6");

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      cyc();
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom);
      s0_valid = ($urandom_range(0, 3) == 0);
      s1_valid = ($urandom_range(0, 4) == 0);
      s0_data  = 16'($urandom);
      s1_data  = 16'($urandom);
      lr_edge  = ($urandom_range(0, 15) == 0);
      if (lr_edge) lr_ws = ($urandom_range(0, 9) == 0) ? lr_ws : ~lr_ws;
`ifdef I2S_SCHED_STATS_EN
      stat_clr = ($urandom_range(0, 199) == 0);
`endif
    end
    rst = 1'b0; lr_edge = 1'b0;
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
